// File: rtl/regfile_alu_sequencer_pkg.sv
// Shared encodings for the regfile/ALU sequencer: FSM states and ALU opcodes.
package seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
endpackage

// File: rtl/regfile_alu_sequencer_if.sv
// Instruction handshake, regfile/ALU ports and retire status of the sequencer.
interface regfile_alu_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic [ADDR_W-1:0] A1_rf;
    logic [ADDR_W-1:0] A2_rf;
    logic [DATA_W-1:0] RD1_rf;
    logic [DATA_W-1:0] RD2_rf;
    logic              WE3_rf;
    logic [ADDR_W-1:0] A3_rf;
    logic [DATA_W-1:0] WD3_rf;
    logic [1:0]        opcode_alu;
    logic [DATA_W-1:0] inputA_alu;
    logic [DATA_W-1:0] inputB_alu;
    logic [DATA_W-1:0] result_alu;
    logic              done;
    logic [DATA_W-1:0] done_result;
    logic [CNT_W-1:0]  retired_cnt;

    // Sequencer side
    modport master (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  RD1_rf, RD2_rf, result_alu,
        output instr_ready, A1_rf, A2_rf, WE3_rf, A3_rf, WD3_rf,
        output opcode_alu, inputA_alu, inputB_alu,
        output done, done_result, retired_cnt
    );

    // Instruction source / regfile / ALU side
    modport slave (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output RD1_rf, RD2_rf, result_alu,
        input  instr_ready, A1_rf, A2_rf, WE3_rf, A3_rf, WD3_rf,
        input  opcode_alu, inputA_alu, inputB_alu,
        input  done, done_result, retired_cnt
    );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WRITE sequencer driving an external regfile and ALU.
// Optional SEQ_R0_ZERO_EN: register 0 reads as hardwired zero, writes to it are suppressed.
module regfile_alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic                     CLK,
    input logic                     RST,
    regfile_alu_sequencer_if.master bus
);
    import seq_pkg::*;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0] opa_q, opb_q, res_q, done_result_q, wb_data;
    logic [CNT_W-1:0]  retired_q;
    logic              wb_en;

`ifdef SEQ_R0_ZERO_EN
    assign wb_en = (rd_q != '0);
`else
    assign wb_en = 1'b1;
`endif
    // A suppressed x0 write still retires, reporting zero as its value.
    assign wb_data = wb_en ? res_q : '0;

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.instr_valid) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.A1_rf       = '0;
        bus.A2_rf       = '0;
        bus.WE3_rf      = 1'b0;
        bus.A3_rf       = '0;
        bus.WD3_rf      = '0;
        bus.opcode_alu  = '0;
        bus.inputA_alu  = '0;
        bus.inputB_alu  = '0;
        bus.done        = 1'b0;
        case (state)
            S_IDLE: bus.instr_ready = 1'b1;
            S_READ: begin
                bus.A1_rf = rs1_q;
                bus.A2_rf = rs2_q;
            end
            S_EXEC: begin
                bus.opcode_alu = op_q;
                bus.inputA_alu = opa_q;
                bus.inputB_alu = opb_q;
            end
            S_WRITE: begin
                // Reset landing on the write cycle drops the instruction entirely.
                bus.WE3_rf = wb_en && !RST;
                bus.A3_rf  = rd_q;
                bus.WD3_rf = wb_data;
                bus.done   = !RST;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q          <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            res_q         <= '0;
            done_result_q <= '0;
            retired_q     <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.instr_valid) begin
                    op_q  <= bus.instr_op;
                    rd_q  <= bus.instr_rd;
                    rs1_q <= bus.instr_rs1;
                    rs2_q <= bus.instr_rs2;
                end
                S_READ: begin
                    opa_q <= bus.RD1_rf;
                    opb_q <= bus.RD2_rf;
                end
                S_EXEC:  res_q <= bus.result_alu;
                S_WRITE: begin
                    done_result_q <= wb_data;
                    retired_q     <= retired_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.done_result = done_result_q;
    assign bus.retired_cnt = retired_q;
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: behavioural regfile + ALU, timestamp-based model, directed tests.
module tb_regfile_alu_sequencer;
    import seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_alu_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) ifc ();

    regfile_alu_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .CLK(clk), .RST(rst), .bus(ifc)
    );

    function automatic logic [DW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            default: return a | b;
        endcase
    endfunction

    // External regfile (combinational reads) with a preload port, and ALU
    logic [DW-1:0] rf [32] = '{default: '0};
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (ifc.WE3_rf)  rf[ifc.A3_rf] <= ifc.WD3_rf;
        else if (pl_we)  rf[pl_addr]   <= pl_data;
    end
    assign ifc.RD1_rf     = rf[ifc.A1_rf];
    assign ifc.RD2_rf     = rf[ifc.A2_rf];
    assign ifc.result_alu = alu_f(ifc.opcode_alu, ifc.inputA_alu, ifc.inputB_alu);

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted instruction is due for write-back 3 cycles later,
    // next accept 4 cycles after the previous one.
    logic [DW-1:0] ref_rf [32] = '{default: '0};
    int            cyc = 0, acc_ok = 0, wr_due = 0;
    bit            armed = 0, pend = 0, m_wb = 0;
    logic [1:0]    m_op = '0;
    logic [AW-1:0] m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_val = '0, m_dres = '0;
    logic [CW-1:0] m_cnt = '0;

    always @(negedge clk) begin
        bit hit, rd_cyc, ex_cyc;
        hit    = pend && cyc == wr_due && !rst;
        rd_cyc = pend && cyc == wr_due - 2;
        ex_cyc = pend && cyc == wr_due - 1;
        if (armed) begin
            chk("ready", ifc.instr_ready, cyc >= acc_ok);
            chk("done", ifc.done, hit);
            chk("we3", ifc.WE3_rf, hit && m_wb);
            if (hit && m_wb) begin
                chk("a3", ifc.A3_rf, m_rd);
                chk("wd3", ifc.WD3_rf, m_val);
            end
            chk("a1", ifc.A1_rf, rd_cyc ? m_rs1 : '0);
            chk("a2", ifc.A2_rf, rd_cyc ? m_rs2 : '0);
            chk("opcode", ifc.opcode_alu, ex_cyc ? m_op : 2'b00);
            chk("inA", ifc.inputA_alu, ex_cyc ? m_a : '0);
            chk("inB", ifc.inputB_alu, ex_cyc ? m_b : '0);
            chk("done_result", ifc.done_result, m_dres);
            chk("retired_cnt", ifc.retired_cnt, m_cnt);
        end
        if (pl_we) ref_rf[pl_addr] = pl_data;
        if (rst) begin
            armed  = 1;
            pend   = 0;
            m_cnt  = '0;
            m_dres = '0;
            acc_ok = cyc + 1;
        end else if (hit) begin
            if (m_wb) ref_rf[m_rd] = m_val;
            m_dres = m_wb ? m_val : '0;
            m_cnt  = m_cnt + 1'b1;
            pend   = 0;
        end else if (ifc.instr_valid && cyc >= acc_ok) begin
            pend   = 1;
            wr_due = cyc + 3;
            acc_ok = cyc + 4;
            m_op   = ifc.instr_op;
            m_rd   = ifc.instr_rd;
            m_rs1  = ifc.instr_rs1;
            m_rs2  = ifc.instr_rs2;
            m_a    = ref_rf[ifc.instr_rs1];
            m_b    = ref_rf[ifc.instr_rs2];
            m_val  = alu_f(m_op, m_a, m_b);
`ifdef SEQ_R0_ZERO_EN
            m_wb   = (m_rd != '0);
`else
            m_wb   = 1;
`endif
        end
        cyc++;
    end

    // Drivers: called at posedge+1; return at posedge+1 of the cycle after the handshake
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        int n;
        n = 0;
        ifc.instr_valid = 1'b1;
        ifc.instr_op = op; ifc.instr_rd = rd; ifc.instr_rs1 = rs1; ifc.instr_rs2 = rs2;
        do begin @(negedge clk); n++; end while (!ifc.instr_ready && n < 20);
        if (n >= 20) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!ifc.done && n < 20);
        if (n >= 20) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        ifc.instr_valid = 1'b0;
        ifc.instr_op = '0; ifc.instr_rd = '0; ifc.instr_rs1 = '0; ifc.instr_rs2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ifc.instr_ready, 1'b1);
        chk("rst_we3", ifc.WE3_rf, 1'b0);
        chk("rst_dres", ifc.done_result, 0);
        chk("rst_cnt", ifc.retired_cnt, 0);
        @(posedge clk); #1;
        preload(1, 5); preload(2, 7); preload(5, 99); preload(0, 32'hA);

        // 1: ADD x3 = x1 + x2, write/done 3 cycles after handshake
        send(ALU_ADD, 3, 1, 2);
        wait_done(n);
        chk("t1_latency", n, 3);
        @(posedge clk); #1;
        chk("t1_x3", rf[3], 12);
        chk("t1_dres", ifc.done_result, 12);
        chk("t1_cnt", ifc.retired_cnt, 1);

        // 2: SUB x4 = x3 - x1 accepted at the earliest slot, sees new x3
        send(ALU_SUB, 4, 3, 1);
        wait_done(n);
        @(posedge clk); #1;
        chk("t2_x4", rf[4], 7);
        chk("t2_cnt", ifc.retired_cnt, 2);

        // 3: reset during EXEC drops the instruction
        send(ALU_ADD, 5, 1, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t3_ready", ifc.instr_ready, 1'b1);
        chk("t3_cnt", ifc.retired_cnt, 0);
        repeat (4) @(posedge clk); #1;
        chk("t3_x5", rf[5], 99);

        // 4: rd = 0
        send(ALU_ADD, 0, 1, 2);
        wait_done(n);
        @(posedge clk); #1;
`ifdef SEQ_R0_ZERO_EN
        chk("t4_x0", rf[0], 32'hA);
        chk("t4_dres", ifc.done_result, 0);
`else
        chk("t4_x0", rf[0], 12);
        chk("t4_dres", ifc.done_result, 12);
`endif
        chk("t4_cnt", ifc.retired_cnt, 1);

        // 5: counter wrap with CNT_W=4
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(ALU_ADD, 6, 1, 2);
            wait_done(n);
            @(posedge clk); #1;
            if (i == 14) chk("t5_cnt15", ifc.retired_cnt, 15);
            if (i == 15) chk("t5_wrap", ifc.retired_cnt, 0);
        end

        // 6: valid held high, fields change every cycle
        ifc.instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ifc.instr_op  = 2'((i + i / 4) % 4);
            ifc.instr_rd  = 5'(10 + i);
            ifc.instr_rs1 = 5'((i % 3) + 1);
            ifc.instr_rs2 = 5'((i % 2) + 1);
            @(posedge clk); #1;
        end
        ifc.instr_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("t6_x10", rf[10], 10);
        chk("t6_x14", rf[14], 2);
        chk("t6_x18", rf[18], 4);
        chk("t6_x11", rf[11], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
